// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, active window, pixel coordinates and line/frame strobes.
// Define VGA_TIMING_PREFETCH_EN to make active/pixel/strobe outputs lead the syncs by one cycle.
module vga_timing_gen #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic       clk25MHz,
    input  logic       reset,
    input  logic       pix_en,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       active,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    typedef enum logic [1:0] {StSync, StBack, StActive, StFront} phase_e;

    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC - 1);
    localparam logic [9:0] H_BACK_END  = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC - 1);
    localparam logic [9:0] V_BACK_END  = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);

    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    phase_e     h_st_q, h_st_d, v_st_q, v_st_d;
    logic       h_last, v_last;

    logic [9:0] dec_h_cnt, dec_v_cnt;
    phase_e     dec_h_st, dec_v_st;
    logic       act_d, ls_d, fs_d, ls_q, fs_q;
    logic [9:0] px_d, py_d;

    // Shared phase sequencing for both axes: leave a phase on its last count.
    function automatic phase_e next_phase(input phase_e cur, input logic [9:0] cnt,
                                          input logic [9:0] sync_end, input logic [9:0] back_end,
                                          input logic [9:0] act_end, input logic [9:0] last);
        phase_e nxt;
        nxt = cur;
        unique case (cur)
            StSync:   if (cnt == sync_end) nxt = StBack;
            StBack:   if (cnt == back_end) nxt = StActive;
            StActive: if (cnt == act_end)  nxt = StFront;
            StFront:  if (cnt == last)     nxt = StSync;
        endcase
        return nxt;
    endfunction

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        h_st_d  = h_st_q;
        v_st_d  = v_st_q;
        if (pix_en) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
            h_st_d  = next_phase(h_st_q, h_cnt_q, H_SYNC_END, H_BACK_END, H_ACT_END, H_LAST);
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
                v_st_d  = next_phase(v_st_q, v_cnt_q, V_SYNC_END, V_BACK_END, V_ACT_END, V_LAST);
            end
        end
    end

`ifdef VGA_TIMING_PREFETCH_EN
    // Decode the upcoming raster position so the pixel path is one cycle ahead of sync.
    assign dec_h_cnt = h_cnt_d;
    assign dec_v_cnt = v_cnt_d;
    assign dec_h_st  = h_st_d;
    assign dec_v_st  = v_st_d;
`else
    assign dec_h_cnt = h_cnt_q;
    assign dec_v_cnt = v_cnt_q;
    assign dec_h_st  = h_st_q;
    assign dec_v_st  = v_st_q;
`endif

    always_comb begin
        act_d = (dec_h_st == StActive) && (dec_v_st == StActive);
        px_d  = act_d ? dec_h_cnt - H_ACT_START : '0;
        py_d  = act_d ? dec_v_cnt - V_ACT_START : '0;
        ls_d  = act_d && (px_d == '0);
        fs_d  = ls_d && (py_d == '0);
    end

    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            h_st_q  <= StSync;
            v_st_q  <= StSync;
            VGA_HS  <= ~HS_POL;
            VGA_VS  <= ~VS_POL;
            active  <= 1'b0;
            pixel_x <= '0;
            pixel_y <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (pix_en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            h_st_q  <= h_st_d;
            v_st_q  <= v_st_d;
            VGA_HS  <= (h_st_q == StSync) ? HS_POL : ~HS_POL;
            VGA_VS  <= (v_st_q == StSync) ? VS_POL : ~VS_POL;
            active  <= act_d;
            pixel_x <= px_d;
            pixel_y <= py_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    // Held strobes are masked while stalled so each pulse is seen for one enabled cycle only.
    assign line_start  = ls_q & pix_en;
    assign frame_start = fs_q & pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster so whole frames run quickly.
module tb_vga_timing_gen;
    localparam int HS = 4, HB = 3, HA = 8, HF = 2, HT = HS + HB + HA + HF;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1, VT = VS + VB + VA + VF;
    localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
`ifdef VGA_TIMING_PREFETCH_EN
    localparam int LEAD = 1;
`else
    localparam int LEAD = 0;
`endif
    localparam int A0 = HS + HB + (VS + VB) * HT + 1 - LEAD;

    logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
    logic VGA_HS, VGA_VS, active, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk25MHz(clk), .reset(reset), .pix_en(pix_en),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .active(active),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int mh, mv;
    logic e_hs, e_vs, e_act, e_ls, e_fs;
    logic [9:0] e_px, e_py;

    typedef struct {
        int         cyc;
        logic       hs, vs, act;
        logic [9:0] px, py;
        logic       ls, fs;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hs"}, 10'(VGA_HS), 10'(e_hs));
        chk({tag, ".vs"}, 10'(VGA_VS), 10'(e_vs));
        chk({tag, ".active"}, 10'(active), 10'(e_act));
        chk({tag, ".px"}, pixel_x, e_px);
        chk({tag, ".py"}, pixel_y, e_py);
        chk({tag, ".ls"}, 10'(line_start), 10'(e_ls));
        chk({tag, ".fs"}, 10'(frame_start), 10'(e_fs));
    endtask

    // Visible-window decode of one raster position, straight from the window arithmetic.
    task automatic decode(input int h, input int v, output logic a, output logic [9:0] x,
                          output logic [9:0] y, output logic l, output logic f);
        a = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        x = a ? 10'(h - (HS + HB)) : 10'd0;
        y = a ? 10'(v - (VS + VB)) : 10'd0;
        l = a && (x == 10'd0);
        f = l && (y == 10'd0);
    endtask

    task automatic model_step(input logic en);
        int nh, nv;
        if (en) begin
            nh = (mh + 1) % HT;
            nv = (mh == HT - 1) ? (mv + 1) % VT : mv;
            e_hs = (mh < HS) ? HS_POL : !HS_POL;
            e_vs = (mv < VS) ? VS_POL : !VS_POL;
            if (LEAD != 0) decode(nh, nv, e_act, e_px, e_py, e_ls, e_fs);
            else decode(mh, mv, e_act, e_px, e_py, e_ls, e_fs);
            mh = nh;
            mv = nv;
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
    endtask

    task automatic cycle(input logic en, input string tag);
        pix_en = en;
        @(posedge clk);
        #1;
        model_step(en);
        check_all(tag);
    endtask

    task automatic apply_reset(input int hold);
        #2;
        reset = 1'b1;
        #1;
        mh = 0; mv = 0;
        e_hs = !HS_POL; e_vs = !VS_POL;
        e_act = 1'b0; e_px = '0; e_py = '0; e_ls = 1'b0; e_fs = 1'b0;
        check_all("reset");
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        reset = 1'b0;
    endtask

    task automatic run_table();
        int c;
        c = 0;
        foreach (tbl[i]) begin
            while (c < tbl[i].cyc) begin
                cycle(1'b1, "tbl_model");
                c++;
            end
            chk($sformatf("tbl%0d.hs", i), 10'(VGA_HS), 10'(tbl[i].hs));
            chk($sformatf("tbl%0d.vs", i), 10'(VGA_VS), 10'(tbl[i].vs));
            chk($sformatf("tbl%0d.act", i), 10'(active), 10'(tbl[i].act));
            chk($sformatf("tbl%0d.px", i), pixel_x, tbl[i].px);
            chk($sformatf("tbl%0d.py", i), pixel_y, tbl[i].py);
            chk($sformatf("tbl%0d.ls", i), 10'(line_start), 10'(tbl[i].ls));
            chk($sformatf("tbl%0d.fs", i), 10'(frame_start), 10'(tbl[i].fs));
        end
    endtask

    task automatic frame_stats(input string tag);
        int hs_cyc, hs_pulses, vs_cyc, ls_n, fs_n, act_n, px_max, py_max;
        logic prev_hs;
        hs_cyc = 0; hs_pulses = 0; vs_cyc = 0; ls_n = 0; fs_n = 0; act_n = 0;
        px_max = 0; py_max = 0;
        prev_hs = VGA_HS;
        repeat (HT * VT) begin
            cycle(1'b1, tag);
            if (VGA_HS == HS_POL) hs_cyc++;
            if (VGA_HS == HS_POL && prev_hs != HS_POL) hs_pulses++;
            prev_hs = VGA_HS;
            if (VGA_VS == VS_POL) vs_cyc++;
            if (line_start) ls_n++;
            if (frame_start) fs_n++;
            if (active) act_n++;
            if (int'(pixel_x) > px_max) px_max = int'(pixel_x);
            if (int'(pixel_y) > py_max) py_max = int'(pixel_y);
        end
        chk({tag, ".hs_cycles"}, 10'(hs_cyc), 10'(HS * VT));
        chk({tag, ".hs_pulses"}, 10'(hs_pulses), 10'(VT));
        chk({tag, ".vs_cycles"}, 10'(vs_cyc), 10'(VS * HT));
        chk({tag, ".line_starts"}, 10'(ls_n), 10'(VA));
        chk({tag, ".frame_starts"}, 10'(fs_n), 10'(1));
        chk({tag, ".active_cycles"}, 10'(act_n), 10'(HA * VA));
        chk({tag, ".px_max"}, 10'(px_max), 10'(HA - 1));
        chk({tag, ".py_max"}, 10'(py_max), 10'(VA - 1));
    endtask

    initial begin
        int guard, fs_seen, fs_at0, fs_at1;
        tbl[0]  = '{1,           1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[1]  = '{HS,          1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[2]  = '{HS + 1,      1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[3]  = '{VS * HT,     1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[4]  = '{VS * HT + 1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[5]  = '{A0 - 1,      1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[6]  = '{A0,          1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1};
        tbl[7]  = '{A0 + 1,      1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0};
        tbl[8]  = '{A0 + HA - 1, 1'b1, 1'b1, 1'b1, 10'(HA - 1), 10'd0, 1'b0, 1'b0};
        tbl[9]  = '{A0 + HA,     1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        tbl[10] = '{A0 + HT,     1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 1'b1, 1'b0};

        // Power-on: reset held 10 cycles, then the fixed opening sequence of the raster.
        apply_reset(10);
        run_table();

        // Reset in the middle of the visible window, then the opening sequence again.
        guard = 0;
        while (!(mh == HS + HB + HA / 2 && mv == VS + VB + VA / 2) && guard < 4 * HT * VT) begin
            cycle(1'b1, "to_mid");
            guard++;
        end
        chk("mid_reached", 10'(guard < 4 * HT * VT), 10'd1);
        cycle(1'b1, "mid");
        apply_reset(3);
        run_table();

        // Two whole frames from a fresh reset.
        apply_reset(2);
        frame_stats("frame1");
        frame_stats("frame2");

        // Frame wrap: last position of the frame, then back to the top with vsync asserting.
        guard = 0;
        while (!(mh == HT - 1 && mv == VT - 1) && guard < 2 * HT * VT) begin
            cycle(1'b1, "to_wrap");
            guard++;
        end
        chk("wrap_reached", 10'(guard < 2 * HT * VT), 10'd1);
        cycle(1'b1, "wrap_last");
        chk("wrap.vs_before", 10'(VGA_VS), 10'(!VS_POL));
        cycle(1'b1, "wrap_first");
        chk("wrap.vs_after", 10'(VGA_VS), 10'(VS_POL));
        chk("wrap.hs_after", 10'(VGA_HS), 10'(HS_POL));

        // pix_en toggling: frame period doubles, held strobes never repeat.
        apply_reset(1);
        fs_seen = 0; fs_at0 = 0; fs_at1 = 0;
        for (int c = 1; c <= 6 * HT * VT && fs_seen < 2; c++) begin
            cycle(1'(c % 2), "toggle");
            if (frame_start) begin
                if (fs_seen == 0) fs_at0 = c;
                else fs_at1 = c;
                fs_seen++;
            end
        end
        chk("toggle.fs_count", 10'(fs_seen), 10'd2);
        chk("toggle.frame_len", 10'((fs_at1 - fs_at0) / 2), 10'(HT * VT));

        // Random enable with occasional resets, checked against the model every cycle.
        apply_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(0, 2));
            else cycle(1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
